// File: rtl/bcd_mixed_radix_down_counter.sv
// Multi-digit BCD down counter with per-digit wrap value (9 or 5).
// Parallel load, count enable, zero detect and a one-cycle expiry pulse.
module bcd_mixed_radix_down_counter #(
  parameter int unsigned           NUM_DIGITS = 4,
  parameter logic [NUM_DIGITS-1:0] WRAP5_MASK = NUM_DIGITS'(4'b0010)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic                    zero,
  output logic                    done_pulse
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = DW * NUM_DIGITS;
  localparam logic [DW-1:0] DIGIT_MAX9 = 4'd9;
  localparam logic [DW-1:0] DIGIT_MAX5 = 4'd5;

  logic [CW-1:0]       count_q, count_d;
  logic                done_pulse_q, done_pulse_d;
  logic [CW-1:0]       dec_value;
  logic [CW-1:0]       load_clean;
  logic [NUM_DIGITS:0] borrow;
  logic [DW-1:0]       cur_digit;
  logic [DW-1:0]       ld_digit;
  logic                zero_c;

  // Zero detect straight off the registered count.
  always_comb begin
    zero_c = (count_q == '0);
  end

  // Borrow chain, per-digit decrement and load sanitising.
  // borrow[i] is set when every digit below i is zero, so digit i decrements.
  always_comb begin
    borrow     = '0;
    borrow[0]  = 1'b1;
    dec_value  = count_q;
    load_clean = load_value;
    cur_digit  = '0;
    ld_digit   = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      cur_digit = count_q[DW*i +: DW];
      borrow[i+1] = borrow[i] & (cur_digit == '0);
      if (borrow[i]) begin
        if (cur_digit == '0) begin
          dec_value[DW*i +: DW] = WRAP5_MASK[i] ? DIGIT_MAX5 : DIGIT_MAX9;
        end else begin
          dec_value[DW*i +: DW] = cur_digit - 4'd1;
        end
      end
      // Non-BCD nibbles clamp to 9; tens digits 6..9 pass through unchanged.
      ld_digit = load_value[DW*i +: DW];
      if (ld_digit > DIGIT_MAX9) begin
        load_clean[DW*i +: DW] = DIGIT_MAX9;
      end
    end
  end

  // Next-state selection: load beats decrement; terminal count holds.
  always_comb begin
    count_d      = count_q;
    done_pulse_d = 1'b0;
    if (load) begin
      count_d = load_clean;
    end else if (en && !zero_c) begin
      count_d      = dec_value;
      done_pulse_d = (dec_value == '0);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q      <= '0;
      done_pulse_q <= 1'b0;
    end else begin
      count_q      <= count_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign count      = count_q;
  assign zero       = zero_c;
  assign done_pulse = done_pulse_q;

endmodule

// File: tb/tb_bcd_mixed_radix_down_counter.sv
// Directed bench for bcd_mixed_radix_down_counter with a digit-array model.
module tb_bcd_mixed_radix_down_counter;

  localparam int          ND = 4;
  localparam logic [3:0]  W5 = 4'b0010;

  logic        clk;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] count;
  logic        zero;
  logic        done_pulse;

  int nvec  = 0;
  int nfail = 0;
  bit checking = 1'b0;

  // Model state: one integer per digit, plus expected pulse.
  int m_d[ND];
  bit m_done;

  bcd_mixed_radix_down_counter #(
    .NUM_DIGITS(ND),
    .WRAP5_MASK(W5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .load(load),
    .load_value(load_value),
    .count(count),
    .zero(zero),
    .done_pulse(done_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] m_pack();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < ND; i++) v[4*i +: 4] = 4'(m_d[i]);
    return v;
  endfunction

  function automatic bit m_is_zero();
    bit z;
    z = 1'b1;
    for (int i = 0; i < ND; i++) if (m_d[i] != 0) z = 1'b0;
    return z;
  endfunction

  // Model: subtract one by taking from the lowest nonzero digit and
  // refilling every digit below it with its maximum.
  always @(posedge clk) begin
    int j;
    int nib;
    if (!rst) begin
      for (int i = 0; i < ND; i++) m_d[i] = 0;
      m_done = 1'b0;
    end else if (load) begin
      for (int i = 0; i < ND; i++) begin
        nib = int'(load_value[4*i +: 4]);
        m_d[i] = (nib > 9) ? 9 : nib;
      end
      m_done = 1'b0;
    end else if (en && !m_is_zero()) begin
      j = -1;
      for (int i = 0; i < ND; i++) if (j < 0 && m_d[i] != 0) j = i;
      m_d[j] = m_d[j] - 1;
      for (int k = 0; k < j; k++) m_d[k] = W5[k] ? 5 : 9;
      m_done = m_is_zero();
    end else begin
      m_done = 1'b0;
    end
  end

  // Per-cycle compare of every output against the model.
  always @(negedge clk) begin
    if (checking) begin
      nvec++;
      if (count !== m_pack() || zero !== m_is_zero() || done_pulse !== m_done) begin
        nfail++;
        $display("FAIL cycle_cmp t=%0t count=%h/%h zero=%b/%b done=%b/%b (dut/model)",
                 $time, count, m_pack(), zero, m_is_zero(), done_pulse, m_done);
      end
    end
  end

  task automatic tick(input logic r, input logic l, input logic e, input logic [15:0] lv);
    rst = r; load = l; en = e; load_value = lv;
    @(posedge clk);
    #1;
  endtask

  // Literal check of DUT and model against a hand-computed value.
  task automatic check_lit(input string name, input logic [15:0] ec, input logic ez, input logic ed);
    nvec++;
    if (count !== ec || zero !== ez || done_pulse !== ed) begin
      nfail++;
      $display("FAIL %s dut count=%h zero=%b done=%b expected %h %b %b",
               name, count, zero, done_pulse, ec, ez, ed);
    end
    nvec++;
    if (m_pack() !== ec || m_is_zero() !== ez || m_done !== ed) begin
      nfail++;
      $display("FAIL %s_model count=%h zero=%b done=%b expected %h %b %b",
               name, m_pack(), m_is_zero(), m_done, ec, ez, ed);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int pulses;
    int pulse_edge;
    rst = 1'b0; en = 1'b0; load = 1'b0; load_value = '0;

    // Reset
    tick(1'b0, 1'b0, 1'b0, 16'h0000);
    tick(1'b0, 1'b1, 1'b1, 16'h1234);
    checking = 1'b1;
    check_lit("reset", 16'h0000, 1'b1, 1'b0);

    // 1: 1:30 down to 0:00
    tick(1'b1, 1'b1, 1'b1, 16'h0130);
    check_lit("t1_load", 16'h0130, 1'b0, 1'b0);
    pulses = 0; pulse_edge = -1;
    for (int n = 1; n <= 93; n++) begin
      tick(1'b1, 1'b0, 1'b1, 16'h0000);
      if (done_pulse) begin pulses++; pulse_edge = n; end
      if (n == 1)  check_lit("t1_e1",  16'h0129, 1'b0, 1'b0);
      if (n == 30) check_lit("t1_e30", 16'h0100, 1'b0, 1'b0);
      if (n == 31) check_lit("t1_e31", 16'h0059, 1'b0, 1'b0);
      if (n == 90) check_lit("t1_e90", 16'h0000, 1'b1, 1'b1);
      if (n == 93) check_lit("t1_hold", 16'h0000, 1'b1, 1'b0);
    end
    check_int("t1_pulses", pulses, 1);
    check_int("t1_pulse_edge", pulse_edge, 90);

    // 2: 75 s with tens digit above 5
    tick(1'b1, 1'b1, 1'b1, 16'h0075);
    pulses = 0;
    for (int n = 1; n <= 77; n++) begin
      tick(1'b1, 1'b0, 1'b1, 16'h0000);
      if (done_pulse) pulses++;
      if (n == 1)  check_lit("t2_e1",  16'h0074, 1'b0, 1'b0);
      if (n == 15) check_lit("t2_e15", 16'h0060, 1'b0, 1'b0);
      if (n == 16) check_lit("t2_e16", 16'h0059, 1'b0, 1'b0);
      if (n == 75) check_lit("t2_e75", 16'h0000, 1'b1, 1'b1);
    end
    check_int("t2_pulses", pulses, 1);

    // 3: load wins over enable mid-count, then multi-digit borrow
    tick(1'b1, 1'b1, 1'b0, 16'h0500);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t3_run", 16'h0459, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 16'h0200);
    check_lit("t3_loadwin", 16'h0200, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t3_borrow", 16'h0159, 1'b0, 1'b0);

    // 4: sanitising and loading zero
    tick(1'b1, 1'b1, 1'b0, 16'hF9AF);
    check_lit("t4_sanit", 16'h9999, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t4_dec", 16'h9998, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1, 16'h0000);
    check_lit("t4_ldzero", 16'h0000, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t4_ldzero_hold", 16'h0000, 1'b1, 1'b0);

    // 5: pause
    tick(1'b1, 1'b1, 1'b0, 16'h0010);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t5_e1", 16'h0009, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 16'h0000);
    check_lit("t5_p1", 16'h0009, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 16'h0000);
    check_lit("t5_p2", 16'h0009, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t5_e2", 16'h0008, 1'b0, 1'b0);

    // 6: reset at 0001 must not pulse; then re-arm
    tick(1'b1, 1'b1, 1'b0, 16'h0001);
    tick(1'b0, 1'b0, 1'b1, 16'h0000);
    check_lit("t6_rst", 16'h0000, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b0, 16'h0003);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t6_e1", 16'h0002, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t6_e2", 16'h0001, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t6_e3", 16'h0000, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 16'h0000);
    check_lit("t6_e4", 16'h0000, 1'b1, 1'b0);

    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/bcd_mixed_radix_down_counter.md
Name: bcd_mixed_radix_down_counter

Overview:
- Parametrised multi-digit BCD down counter for the timer datapath.
- Replaces the separate per-digit counters: one block holds NUM_DIGITS BCD digits.
- Each digit has a configurable wrap value: 9 for decimal digits, 5 for tens-of-seconds and tens-of-minutes digits.
- Supports parallel load, count enable, zero detect and a single-cycle expiry pulse. Feeds the display mux and the cook-control FSM.

Parameters:
- NUM_DIGITS, 4, number of BCD digits; digit 0 is the least significant.
- WRAP5_MASK, 4'b0010, bit i = 1 means digit i wraps 0->5 on borrow, else 0->9. Default gives MM:SS.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; synchronous, active-low
- en  input  1  count enable, active-high; one decrement per enabled cycle
- load  input  1  parallel load strobe, active-high
- load_value  input  4*NUM_DIGITS  BCD load data; digit i at bits [4i+3:4i]
- count  output  4*NUM_DIGITS  current BCD value, registered
- zero  output  1  high when every digit of count is 0 (combinational from count)
- done_pulse  output  1  one-cycle high when a decrement brings count to zero, registered

Behaviour:
- Reset (rst=0 at a rising edge):
  - count = 0 and done_pulse = 0; zero therefore = 1.
  - rst has priority over load and en.
- Priority per edge is rst > load > en. When none is active, count holds.
- Load:
  - count <= load_value with per-digit sanitising: a digit nibble > 9 (A-F) is stored as 9.
  - A tens digit with wrap 5 may be loaded with 6..9 and stored unchanged. Example: 75 s counts 75,74,...,60,59, i.e. seconds > 59 count down normally to 00.
  - done_pulse <= 0 on load, even when load_value is 0.
- Decrement, when en=1, load=0 and zero=0:
  - Digit 0 always decrements.
  - Digit i>0 decrements only when digits 0..i-1 are all 0 (borrow chain).
  - A decrementing digit at 0 wraps to 5 if WRAP5_MASK[i] is set, else to 9. Otherwise it becomes d-1.
  - The chain is computed combinationally from the current count; all digits update on the same edge.
  - A decrement always completes in a single cycle, whatever the number of digits.
- Terminal behaviour:
  - When zero=1 and en=1, count holds at 0; there is no wrap to all-max.
  - done_pulse <= 1 only on the edge where a decrement takes count from nonzero to 0. It is 0 on every following cycle while holding.
  - Reloading a nonzero value re-arms done_pulse.
- Pause: en=0 holds count and leaves zero unchanged; done_pulse is 0 on the next edge.
- Latency: count reflects load/decrement 1 cycle after the edge. zero follows count with no extra delay. done_pulse is asserted in the same cycle that count first shows 0.
- Reset mid-count: the next edge forces count=0 and done_pulse=0. It must not produce a done_pulse.
- Widths: all digit arithmetic is 4-bit. No binary conversion; count is always valid BCD after the first load, except loaded tens values 6..9, which are legal.

Test Plan:
1. Reset, then load 16'h0130 with en=1 held -> count 0129 after 1 edge, 0100 after 30, 0059 after 31, 0000 after 90 edges. done_pulse high exactly on edge 90; zero=1 from then on; count stays 0000 with en held.
2. Load 16'h0075, en=1 -> 0074 after 1 edge, 0060 after 15, 0059 after 16 (tens 6 -> 5, no wrap), 0000 after 75. Exactly one done_pulse.
3. Load and en both high with load_value 16'h0200 while counting -> count = 0200 (load wins). Next enabled edge gives 0159 (digit1 wraps to 5, digit 2 to 1, digit 0 to 9).
4. Load 16'hF9AF -> stored 9999. Then 1 enabled edge -> 9998. Load 16'h0000 -> zero=1, done_pulse stays 0.
5. Count from 0010 with en toggling 1,0,0,1 -> 0009, 0009, 0009, 0008. done_pulse 0 throughout.
6. Drive rst=0 for one edge at count 0001 with en=1 -> count 0000, done_pulse 0, zero=1. Release rst, load 0003, en=1 -> done_pulse on 3rd edge only.
